// File: rtl/dac_spi_tx.sv
// Serialises a 10-bit sample into one 16-bit MCP4911-style SPI write frame (mode 0,0, MSB first).
// Optional macro DAC_SPI_LDAC_EN drives dac_ld_n low during the post-frame gap; otherwise dac_ld_n is tied 0.
module dac_spi_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter logic        BUF     = 1'b0,
   parameter logic        GA_N    = 1'b1,
   parameter logic        SHDN_N  = 1'b1
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [9:0] data_in,
   input  logic       load,
   output logic       ready,
   output logic       frame_done,
   output logic       dac_cs_n,
   output logic       dac_sck,
   output logic       dac_sdi,
   output logic       dac_ld_n
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_TRAIL = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [1:0]  r_state;
   logic [7:0]  r_div;
   logic [4:0]  r_phase;
   logic [14:0] r_shreg;
   logic        r_ready;
   logic        r_cs_n;
   logic        r_sck;
   logic        r_sdi;
   logic        r_done;

   wire logic        w_div_end = (r_div == DIV_LAST);
   wire logic [15:0] w_word    = {1'b0, BUF, GA_N, SHDN_N, data_in, 2'b00};

   // r_phase counts 32 half-bit phases: even = SCK low, odd = SCK high
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_div   <= 8'd0;
         r_phase <= 5'd0;
         r_ready <= 1'b1;
         r_cs_n  <= 1'b1;
         r_sck   <= 1'b0;
         r_sdi   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_state <= ST_SHIFT;
                  r_div   <= 8'd0;
                  r_phase <= 5'd0;
                  r_sdi   <= w_word[15];
                  r_cs_n  <= 1'b0;
                  r_ready <= 1'b0;
                  r_sck   <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (w_div_end) begin
                  r_div <= 8'd0;
                  if (r_phase == 5'd31) begin
                     r_state <= ST_TRAIL;
                     r_sck   <= 1'b0;
                  end else begin
                     r_phase <= r_phase + 5'd1;
                     r_sck   <= ~r_phase[0];
                     // Next bit is presented only as a new low phase begins
                     if (r_phase[0])
                        r_sdi <= r_shreg[14];
                  end
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            ST_TRAIL: begin
               if (w_div_end) begin
                  r_state <= ST_GAP;
                  r_div   <= 8'd0;
                  r_cs_n  <= 1'b1;
                  r_done  <= 1'b1;
                  r_sdi   <= 1'b0;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
            default: begin
               if (w_div_end) begin
                  r_state <= ST_IDLE;
                  r_div   <= 8'd0;
                  r_ready <= 1'b1;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end
         endcase
      end
   end

   // Shift data carries no reset; it is reloaded on every accept
   always_ff @(posedge sysclk) begin
      if (r_state == ST_IDLE && load)
         r_shreg <= w_word[14:0];
      else if (r_state == ST_SHIFT && w_div_end && r_phase[0] && r_phase != 5'd31)
         r_shreg <= {r_shreg[13:0], 1'b0};
   end

`ifdef DAC_SPI_LDAC_EN
   logic r_ld_n;

   always_ff @(posedge sysclk) begin
      if (!rst_n)
         r_ld_n <= 1'b1;
      else if (r_state == ST_TRAIL && w_div_end)
         r_ld_n <= 1'b0;
      else if (r_state == ST_GAP && w_div_end)
         r_ld_n <= 1'b1;
   end

   assign dac_ld_n = r_ld_n;
`else
   assign dac_ld_n = 1'b0;
`endif

   assign ready      = r_ready;
   assign frame_done = r_done;
   assign dac_cs_n   = r_cs_n;
   assign dac_sck    = r_sck;
   assign dac_sdi    = r_sdi;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=4 and CLK_DIV=1) with a frame-capturing monitor and scoreboard.
module tb_dac_spi_tx;

`ifdef DAC_SPI_LDAC_EN
   localparam bit LDAC_EN = 1'b1;
`else
   localparam bit LDAC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] din [2];
   logic       ld  [2];
   wire  [1:0] rdy, fd, cs, sck, sdi, ldn;

   always #5 clk = ~clk;

   dac_spi_tx #(.CLK_DIV(4)) u_a (
      .sysclk(clk), .rst_n(rst_n), .data_in(din[0]), .load(ld[0]),
      .ready(rdy[0]), .frame_done(fd[0]), .dac_cs_n(cs[0]), .dac_sck(sck[0]),
      .dac_sdi(sdi[0]), .dac_ld_n(ldn[0]));

   dac_spi_tx #(.CLK_DIV(1)) u_b (
      .sysclk(clk), .rst_n(rst_n), .data_in(din[1]), .load(ld[1]),
      .ready(rdy[1]), .frame_done(fd[1]), .dac_cs_n(cs[1]), .dac_sck(sck[1]),
      .dac_sdi(sdi[1]), .dac_ld_n(ldn[1]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   task automatic push(input int d, input logic [15:0] w);
      if (d == 0) q0.push_back(w);
      else        q1.push_back(w);
   endtask

   function automatic logic [15:0] model_word(input logic [9:0] v);
      return {1'b0, 1'b0, 1'b1, 1'b1, v, 2'b00};
   endfunction

   // Monitor state, one slot per instance
   int          dv [2] = '{4, 1};
   int          t_acc [2], t_fall [2], last_rise [2], nbits [2], per_bad [2];
   int          stray [2], fd_cnt [2], ld_cnt [2], ld_bad [2];
   logic [15:0] cap [2];
   bit          p_cs [2], p_sck [2], p_rdy [2], abort [2];
   bit          mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            logic        c, s, r, f, l;
            logic [15:0] w;
            c = cs[d]; s = sck[d]; r = rdy[d]; f = fd[d]; l = ldn[d];
            if (!rst_n && (!c || !p_cs[d])) abort[d] = 1'b1;
            if (!r && p_rdy[d]) begin
               t_acc[d] = cyc; nbits[d] = 0; cap[d] = '0; per_bad[d] = 0;
               fd_cnt[d] = 0; ld_cnt[d] = 0; ld_bad[d] = 0;
            end
            if (!c && p_cs[d]) t_fall[d] = cyc;
            if (s && !p_sck[d]) begin
               if (c) stray[d]++;
               else begin
                  if (nbits[d] == 0) begin
                     if (cyc - t_acc[d] != dv[d]) per_bad[d]++;
                  end else if (cyc - last_rise[d] != 2 * dv[d]) per_bad[d]++;
                  cap[d] = {cap[d][14:0], sdi[d]};
                  nbits[d]++;
                  last_rise[d] = cyc;
               end
            end
            if (f) fd_cnt[d]++;
            if (LDAC_EN) begin
               if (!l) begin
                  ld_cnt[d]++;
                  if (!c || r) ld_bad[d]++;
               end
            end else if (l !== 1'b0) ld_cnt[d]++;
            if (c && !p_cs[d]) begin
               if (d == 0) w = (q0.size() > 0) ? q0.pop_front() : 16'hxxxx;
               else        w = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
               if (!abort[d]) begin
                  chk("frame_word", cap[d], w);
                  chk("sck_rises", nbits[d], 16);
                  chk("sck_period", per_bad[d], 0);
                  chk("cs_fall_time", t_fall[d] - t_acc[d], 0);
                  chk("cs_rise_time", cyc - t_acc[d], 33 * dv[d]);
                  chk("frame_done_on_rise", f, 1);
                  chk("stray_sck", stray[d], 0);
               end
            end
            if (r && !p_rdy[d]) begin
               if (abort[d]) abort[d] = 1'b0;
               else begin
                  chk("ready_time", cyc - t_acc[d], 34 * dv[d]);
                  chk("frame_done_cycles", fd_cnt[d], 1);
                  if (LDAC_EN) begin
                     chk("ld_low_cycles", ld_cnt[d], dv[d]);
                     chk("ld_low_placement", ld_bad[d], 0);
                  end else
                     chk("ld_tied_low", ld_cnt[d], 0);
               end
            end
            p_cs[d] = c; p_sck[d] = s; p_rdy[d] = r;
         end
      end
   end

   task automatic wait_done(input int d);
      int n = 0;
      while (rdy[d] !== 1'b1 && n < 40 * dv[d] + 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_in_time", rdy[d], 1);
   endtask

   task automatic send(input int d, input logic [9:0] v, input logic [15:0] w);
      @(negedge clk);
      chk("idle_before_send", rdy[d], 1);
      ld[d] = 1'b1; din[d] = v;
      push(d, w);
      @(negedge clk);
      ld[d] = 1'b0; din[d] = ~v;
      wait_done(d);
   endtask

   typedef struct {
      int          d;
      logic [9:0]  din;
      logic [15:0] word;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          k, act;
      logic [9:0]  v0, v1;
      tbl[0] = '{0, 10'h200, 16'h3800};
      tbl[1] = '{0, 10'h3FF, 16'h3FFC};
      tbl[2] = '{0, 10'h000, 16'h3000};
      tbl[3] = '{0, 10'h2AA, 16'h3AA8};
      tbl[4] = '{1, 10'h155, 16'h3554};
      tbl[5] = '{1, 10'h3FF, 16'h3FFC};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin ld[d] = 1'b0; din[d] = '0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", rdy[d], 1);
         chk("rst_cs_n", cs[d], 1);
         chk("rst_sck", sck[d], 0);
         chk("rst_sdi", sdi[d], 0);
         chk("rst_frame_done", fd[d], 0);
         chk("rst_ld_n", ldn[d], LDAC_EN ? 1 : 0);
         p_cs[d] = 1'b1; p_sck[d] = 1'b0; p_rdy[d] = 1'b1;
      end
      rst_n = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 6; i++)
         send(tbl[i].d, tbl[i].din, tbl[i].word);

      // Load held high with changing data: only the accept-edge value is sent
      @(negedge clk);
      chk("busy_idle", rdy[0], 1);
      v0 = 10'h0F0; v1 = 10'h30F;
      ld[0] = 1'b1; din[0] = v0;
      push(0, model_word(v0));
      k = cyc + 1;
      while (cyc < k + 136) begin
         @(negedge clk);
         if (cyc < k + 136) din[0] = 10'($urandom);
      end
      din[0] = v1;
      push(0, model_word(v1));
      chk("busy_gap_cs_high", cs[0], 1);
      chk("busy_ready_k137", rdy[0], 1);
      @(negedge clk);
      chk("busy_next_cs_low_k138", cs[0], 0);
      ld[0] = 1'b0; din[0] = '0;
      wait_done(0);

      // Reset mid-frame aborts it
      @(negedge clk);
      ld[0] = 1'b1; din[0] = 10'h3C3;
      push(0, model_word(10'h3C3));
      @(negedge clk);
      ld[0] = 1'b0;
      repeat (40) @(negedge clk);
      chk("pre_reset_busy", cs[0], 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", cs[0], 1);
      chk("abort_sck", sck[0], 0);
      chk("abort_sdi", sdi[0], 0);
      chk("abort_ready", rdy[0], 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (100) begin
         @(negedge clk);
         if (cs[0] !== 1'b1 || sck[0] !== 1'b0) act++;
      end
      chk("post_reset_idle", act, 0);

      send(0, 10'h155, 16'h3554);
      repeat (5) @(negedge clk);
      chk("stray_sck_final", stray[0] + stray[1], 0);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
